// File: rtl/sqrt_share_arbiter_if.sv
// Requester-side and core-side signals of the shared square-root arbiter.
interface sqrt_share_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned BW_IN = 10,
  parameter int unsigned ID_W  = 2
);
  localparam int unsigned BW_OUT = BW_IN / 2;

  // requester side
  logic [N_REQ-1:0]       Req;
  logic [N_REQ*BW_IN-1:0] Din;
  logic [N_REQ-1:0]       Grant;
  logic [BW_OUT-1:0]      Dout;
  logic                   DoutValid;
  logic [ID_W-1:0]        DoutId;
  logic                   Err;
  logic                   Busy;
  // core side
  logic                   SqStart;
  logic [BW_IN-1:0]       SqIn;
  logic [BW_OUT-1:0]      SqOut;
  logic                   SqBusy;
  logic                   SqEnd;

  // arbiter view
  modport slave (
    input  Req, Din, SqOut, SqBusy, SqEnd,
    output Grant, Dout, DoutValid, DoutId, Err, Busy, SqStart, SqIn
  );

  // environment view (requesters plus core)
  modport master (
    output Req, Din, SqOut, SqBusy, SqEnd,
    input  Grant, Dout, DoutValid, DoutId, Err, Busy, SqStart, SqIn
  );
endinterface

// File: rtl/sqrt_share_arbiter.sv
// Round-robin sharing of one iterative square-root core among N_REQ requesters,
// with a watchdog that abandons a job whose core never reports End.
module sqrt_share_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned BW_IN   = 10,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 63,
  parameter int unsigned TO_W    = 6
) (
  input logic Clock,
  input logic Reset,
  sqrt_share_arbiter_if.slave bus
);
  localparam int unsigned BW_OUT = BW_IN / 2;

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t              state, state_nx;
  logic [ID_W-1:0]     ptr, ptr_nx;
  logic [TO_W-1:0]     wd, wd_nx;

  logic [N_REQ-1:0]    grant_q, grant_nx;
  logic [BW_OUT-1:0]   dout_q, dout_nx;
  logic                dvalid_q, dvalid_nx;
  logic [ID_W-1:0]     did_q, did_nx;
  logic                err_q, err_nx;
  logic                busy_q, busy_nx;
  logic                start_q, start_nx;
  logic [BW_IN-1:0]    sqin_q, sqin_nx;

  logic                found;
  logic [ID_W-1:0]     winner;
  logic [BW_IN-1:0]    operand;
  int unsigned         idx;

  // core Busy is informational only; sequencing relies on End and the watchdog
  logic unused_sqbusy;
  assign unused_sqbusy = bus.SqBusy;

  // Round-robin search starting at ptr; picks the winner and its operand
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    operand = '0;
    idx     = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(ptr) + k) % N_REQ;
      if (!found && |(bus.Req & (N_REQ'(1) << idx))) begin
        found   = 1'b1;
        winner  = ID_W'(idx);
        operand = BW_IN'(bus.Din >> (idx * BW_IN));
      end
    end
  end

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = START;
      START:   state_nx = WAIT;
      WAIT:    if (bus.SqEnd || wd == TO_W'(TIMEOUT - 1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and watchdog
  always_comb begin
    grant_nx  = '0;
    start_nx  = 1'b0;
    dvalid_nx = 1'b0;
    err_nx    = 1'b0;
    dout_nx   = dout_q;
    did_nx    = did_q;
    busy_nx   = busy_q;
    sqin_nx   = sqin_q;
    ptr_nx    = ptr;
    wd_nx     = wd;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nx = N_REQ'(1) << winner;
          start_nx = 1'b1;
          sqin_nx  = operand;
          did_nx   = winner;
          busy_nx  = 1'b1;
          ptr_nx   = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
        end
      end
      START: wd_nx = '0;
      WAIT: begin
        wd_nx = wd + TO_W'(1);
        if (bus.SqEnd) begin
          dout_nx   = bus.SqOut;
          dvalid_nx = 1'b1;
          busy_nx   = 1'b0;
        end else if (wd == TO_W'(TIMEOUT - 1)) begin
          err_nx  = 1'b1;
          busy_nx = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Output, pointer and watchdog registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      grant_q  <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      did_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      sqin_q   <= '0;
      ptr      <= '0;
      wd       <= '0;
    end else begin
      grant_q  <= grant_nx;
      dout_q   <= dout_nx;
      dvalid_q <= dvalid_nx;
      did_q    <= did_nx;
      err_q    <= err_nx;
      busy_q   <= busy_nx;
      start_q  <= start_nx;
      sqin_q   <= sqin_nx;
      ptr      <= ptr_nx;
      wd       <= wd_nx;
    end
  end

  assign bus.Grant     = grant_q;
  assign bus.Dout      = dout_q;
  assign bus.DoutValid = dvalid_q;
  assign bus.DoutId    = did_q;
  assign bus.Err       = err_q;
  assign bus.Busy      = busy_q;
  assign bus.SqStart   = start_q;
  assign bus.SqIn      = sqin_q;
endmodule

// File: tb/tb_sqrt_share_arbiter.sv
// Directed bench: behavioural sqrt core with programmable latency plus a result scoreboard.
module tb_sqrt_share_arbiter;
  localparam int unsigned N_REQ   = 4;
  localparam int unsigned BW_IN   = 10;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned TIMEOUT = 63;
  localparam int unsigned TO_W    = 6;
  localparam int unsigned BW_OUT  = BW_IN / 2;

  typedef struct {
    int id;
    int data;
    bit err;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   core_lat = 5;
  int   core_cnt;
  logic [BW_OUT-1:0] core_res;
  int   din_v [4];
  exp_t sb [$];

  sqrt_share_arbiter_if #(.N_REQ(N_REQ), .BW_IN(BW_IN), .ID_W(ID_W)) bus ();

  sqrt_share_arbiter #(
    .N_REQ(N_REQ), .BW_IN(BW_IN), .ID_W(ID_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Core model: Start sampled, End pulses core_lat edges later; core_lat==0 never ends
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      core_cnt    <= 0;
      core_res    <= '0;
      bus.SqEnd   <= 1'b0;
      bus.SqOut   <= '0;
    end else if (bus.SqStart) begin
      core_cnt  <= core_lat;
      core_res  <= BW_OUT'(isqrt(int'(bus.SqIn)));
      bus.SqEnd <= 1'b0;
    end else begin
      bus.SqEnd <= (core_cnt == 1);
      if (core_cnt == 1) bus.SqOut <= core_res;
      if (core_cnt != 0) core_cnt <= core_cnt - 1;
    end
  end
  assign bus.SqBusy = (core_cnt != 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_din(input int i, input int v);
    bus.Din = (bus.Din & ~(40'h3FF << (i * 10))) | (40'(v) << (i * 10));
    din_v[2'(i)] = v;
  endtask

  task automatic push_exp(input int id, input int data, input bit err);
    exp_t e;
    e.id = id; e.data = data; e.err = err;
    sb.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 32'(bus.Grant), 0);
    check({tag, "_dout"}, 32'(bus.Dout), 0);
    check({tag, "_dvalid"}, 32'(bus.DoutValid), 0);
    check({tag, "_did"}, 32'(bus.DoutId), 0);
    check({tag, "_err"}, 32'(bus.Err), 0);
    check({tag, "_busy"}, 32'(bus.Busy), 0);
    check({tag, "_sqstart"}, 32'(bus.SqStart), 0);
    check({tag, "_sqin"}, 32'(bus.SqIn), 0);
  endtask

  // Wait (bounded) for a grant; n counts negedges waited
  task automatic get_grant(output logic [3:0] g, output int n);
    n = 0;
    g = '0;
    do begin
      @(negedge Clock);
      n++;
    end while (bus.Grant == 0 && n < 100);
    g = bus.Grant;
  endtask

  // One job: grant for exp_id, then result popped from the scoreboard
  task automatic serve_one(input string tag, input int exp_id, input int exp_lat);
    logic [3:0] g;
    int n;
    exp_t e;
    get_grant(g, n);
    check({tag, "_grant_lat"}, 32'(n), 1);
    check({tag, "_grant"}, 32'(g), 32'(1 << exp_id));
    check({tag, "_sqstart"}, 32'(bus.SqStart), 1);
    check({tag, "_sqin"}, 32'(bus.SqIn), 32'(din_v[2'(exp_id)]));
    check({tag, "_busy_on"}, 32'(bus.Busy), 1);
    check({tag, "_did_grant"}, 32'(bus.DoutId), 32'(exp_id));
    check({tag, "_no_stale_pulse"}, 32'({bus.DoutValid, bus.Err}), 0);
    bus.Req = bus.Req & ~(4'(1) << exp_id);
    @(negedge Clock);
    n = 1;
    check({tag, "_grant_pulse"}, 32'({bus.Grant != 0, bus.SqStart}), 0);
    while (!(bus.DoutValid || bus.Err) && n < 200) begin
      @(negedge Clock);
      n++;
    end
    check({tag, "_result_seen"}, 32'(bus.DoutValid || bus.Err), 1);
    if (exp_lat != 0) check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_did"}, 32'(bus.DoutId), 32'(e.id));
      check({tag, "_dvalid"}, 32'(bus.DoutValid), 32'(!e.err));
      check({tag, "_err"}, 32'(bus.Err), 32'(e.err));
      if (!e.err) check({tag, "_dout"}, 32'(bus.Dout), 32'(e.data));
    end
    check({tag, "_busy_off"}, 32'(bus.Busy), 0);
  endtask

  initial begin
    logic [3:0] g;
    int n;
    int seen;
    bus.Req = '0;
    bus.Din = '0;
    for (int i = 0; i < 4; i++) din_v[i] = 0;

    // reset values
    repeat (2) @(negedge Clock);
    check_all_zero("reset");
    Reset = 1'b0;
    @(negedge Clock);

    // T1 single request
    set_din(0, 144);
    bus.Req = 4'b0001;
    push_exp(0, 12, 1'b0);
    serve_one("t1", 0, 7);

    // T2 contention from ptr=0
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    set_din(0, 4); set_din(1, 9); set_din(2, 16); set_din(3, 1023);
    bus.Req = 4'b1111;
    push_exp(0, 2, 1'b0); push_exp(1, 3, 1'b0); push_exp(2, 4, 1'b0); push_exp(3, 31, 1'b0);
    serve_one("t2_r0", 0, 7);
    serve_one("t2_r1", 1, 7);
    serve_one("t2_r2", 2, 7);
    serve_one("t2_r3", 3, 7);

    // T3 fairness: ptr back at 0, then 1
    set_din(0, 25); set_din(3, 36);
    bus.Req = 4'b1001;
    push_exp(0, 5, 1'b0); push_exp(3, 6, 1'b0);
    serve_one("t3_first", 0, 7);
    serve_one("t3_second", 3, 7);

    // T4 watchdog: core never ends
    core_lat = 0;
    set_din(1, 100);
    bus.Req = 4'b0010;
    push_exp(1, 0, 1'b1);
    serve_one("t4_abort", 1, 64);
    core_lat = 5;
    set_din(0, 81);
    bus.Req = 4'b0001;
    push_exp(0, 9, 1'b0);
    serve_one("t4_recover", 0, 7);

    // T5 reset mid-job
    set_din(3, 400);
    bus.Req = 4'b1000;
    get_grant(g, n);
    check("t5_grant", 32'(g), 32'(4'b1000));
    bus.Req = '0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    #1;
    check_all_zero("t5_reset");
    @(negedge Clock);
    Reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clock);
      if (bus.DoutValid || bus.Err) seen++;
    end
    check("t5_no_result", 32'(seen), 0);
    set_din(2, 49);
    bus.Req = 4'b0100;
    push_exp(2, 7, 1'b0);
    serve_one("t5_after", 2, 7);

    // T6 edge values
    set_din(1, 0);
    bus.Req = 4'b0010;
    push_exp(1, 0, 1'b0);
    serve_one("t6_zero", 1, 7);
    set_din(3, 1023);
    bus.Req = 4'b1000;
    push_exp(3, 31, 1'b0);
    serve_one("t6_max", 3, 7);
    core_lat = 62;
    set_din(0, 200);
    bus.Req = 4'b0001;
    push_exp(0, 14, 1'b0);
    serve_one("t6_coincide", 0, 64);
    @(negedge Clock);
    check("t6_no_late_err", 32'({bus.Err, bus.DoutValid}), 0);
    check("t6_sb_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
